// File: rtl/frame_scheduler.sv
// Byte-serial frame loader that time-multiplexes one processing unit over the channels of a frame.
// Optional proc_done watchdog: define SCHED_TIMEOUT_EN.
module frame_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_en_raw,
  input  logic [7:0]              data_in,
  input  logic                    clr_overrun,
  output logic                    proc_start,
  output logic [1:0]              proc_ch,
  output logic [DATA_WIDTH-1:0]   proc_sample,
  input  logic                    proc_done,
  input  logic                    proc_event,
  output logic [NUM_CHANNELS-1:0] event_flags,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);
  localparam int BYTES_PER_FRAME = NUM_CHANNELS * DATA_WIDTH / 8;
  localparam int FRAME_W         = NUM_CHANNELS * DATA_WIDTH;
  localparam int CNT_W           = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_FRAME - 1);
  localparam logic [1:0]       LAST_CH   = 2'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;
  state_t state_reg, state_next;

  logic                    we_q_reg, we_prev_reg;
  logic [CNT_W-1:0]        byte_cnt_reg;
  logic [FRAME_W-1:0]      frame_reg, frame_next, work_reg;
  logic [1:0]              ch_reg;
  logic [NUM_CHANNELS-1:0] event_reg, ch_sel;
  logic                    overrun_reg;
  logic                    accept, frame_complete, last_ch, chan_done, timeout_hit;

  assign accept         = we_q_reg & ~we_prev_reg;
  assign frame_complete = accept && (byte_cnt_reg == LAST_BYTE);
  assign last_ch        = (ch_reg == LAST_CH);
  assign chan_done      = (state_reg == WAIT) && (proc_done || timeout_hit);

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch_sel
    assign ch_sel[gi] = (ch_reg == 2'(gi));
  end

  // Merge the incoming byte so the last byte of a frame reaches the working register in the same cycle.
  always_comb begin
    frame_next = frame_reg;
    for (int i = 0; i < BYTES_PER_FRAME; i++) begin
      if (accept && byte_cnt_reg == CNT_W'(BYTES_PER_FRAME - 1 - i))
        frame_next[i*8 +: 8] = data_in;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt_reg;
  logic            timeout_reg;

  assign timeout_hit = (state_reg == WAIT) && !proc_done &&
                       (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + TO_W'(1) : '0;
      if (timeout_hit) timeout_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Watchdog absent: flag is constant 0 (TIMEOUT_CYCLES is always positive).
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      we_q_reg     <= 1'b0;
      we_prev_reg  <= 1'b0;
      byte_cnt_reg <= '0;
      frame_reg    <= '0;
      work_reg     <= '0;
      ch_reg       <= '0;
      event_reg    <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      we_q_reg    <= write_en_raw;
      we_prev_reg <= we_q_reg;
      frame_reg   <= frame_next;
      if (accept)
        byte_cnt_reg <= (byte_cnt_reg == LAST_BYTE) ? '0 : byte_cnt_reg + CNT_W'(1);
      if (frame_complete && state_reg == IDLE)
        work_reg <= frame_next;
      if (state_reg == IDLE)
        ch_reg <= '0;
      else if (state_reg == NEXT)
        ch_reg <= last_ch ? 2'd0 : ch_reg + 2'd1;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (chan_done && ch_sel[i]) event_reg[i] <= proc_done & proc_event;
      end
      if (frame_complete && state_reg != IDLE)
        overrun_reg <= 1'b1;
      else if (clr_overrun)
        overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_complete) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (chan_done) state_next = NEXT;
      NEXT:    state_next = last_ch ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    proc_start  = (state_reg == ISSUE);
    busy        = (state_reg != IDLE);
    frame_done  = (state_reg == NEXT) && last_ch;
    proc_sample = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (busy && ch_sel[i]) proc_sample = work_reg[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign proc_ch     = ch_reg;
  assign event_flags = event_reg;
  assign overrun     = overrun_reg;
endmodule
